// File: rtl/fpu_divide.sv
// fpu_divide: iterative IEEE-754 divider (result = a / b).
// Radix-2 restoring mantissa division, one quotient bit per clock.
// Subnormal operands read as signed zero; results below the normal range flush to zero.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | in_ready=1, waiting for in_valid; operands latched on accept
//   DIVIDE | first cycle classifies/unpacks, then FW+3 quotient-bit cycles
//   NORM   | normalize, round to nearest even, range check
//   DONE   | out_valid=1, result/flags held until out_ready
module fpu_divide #(
    parameter int  double = 0,
    localparam int W      = (double != 0) ? 64 : 32,
    localparam int EW     = (double != 0) ? 11 : 8,
    localparam int FW     = (double != 0) ? 52 : 23
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic [3:0]   flags
);

    localparam int MW   = FW + 1;            // mantissa width including hidden one
    localparam int QW   = FW + 3;            // quotient bits produced
    localparam int CW   = $clog2(QW);
    localparam int BIAS = (1 << (EW - 1)) - 1;
    localparam int EMAX = (1 << EW) - 1;

    localparam logic signed [EW+1:0] BIAS_X = (EW + 2)'(BIAS);
    localparam logic signed [EW+1:0] EMAX_X = (EW + 2)'(EMAX);
    localparam logic signed [EW+1:0] ONE_X  = (EW + 2)'(1);
    localparam logic signed [EW+1:0] ZERO_X = (EW + 2)'(0);
    localparam logic [W-1:0]         QNAN   = {1'b0, {EW{1'b1}}, 1'b1, {(FW - 1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;

    state_t               state;
    logic [W-1:0]         a_q;
    logic [W-1:0]         b_q;
    logic                 first;
    logic [MW:0]          rem;
    logic [MW-1:0]        dvs;
    logic [QW-1:0]        quo;
    logic signed [EW+1:0] exp_q;
    logic [CW-1:0]        cnt;

    // operand fields, held stable in a_q/b_q for the whole operation
    logic          sa, sb, sq;
    logic [EW-1:0] ea, eb;
    logic [FW-1:0] fa, fb;
    logic          a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [W-1:0]  inf_w, zero_w;

    assign {sa, ea, fa} = a_q;
    assign {sb, eb, fb} = b_q;
    assign sq     = sa ^ sb;
    assign a_nan  = (&ea) && (|fa);
    assign b_nan  = (&eb) && (|fb);
    assign a_inf  = (&ea) && !(|fa);
    assign b_inf  = (&eb) && !(|fb);
    assign a_zero = ~|ea;
    assign b_zero = ~|eb;
    assign inf_w  = {sq, {EW{1'b1}}, {FW{1'b0}}};
    assign zero_w = {sq, {(W - 1){1'b0}}};

    logic                 spec_hit;
    logic [W-1:0]         spec_res;
    logic [3:0]           spec_flags;
    logic signed [EW+1:0] exp_init;

    assign exp_init = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_X;

    // special-operand decode in priority order
    always_comb begin
        spec_hit   = 1'b1;
        spec_res   = zero_w;
        spec_flags = 4'b0000;
        if (a_nan || b_nan) begin
            spec_res = QNAN;
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_res   = QNAN;
            spec_flags = 4'b1000;
        end else if (a_inf) begin
            spec_res = inf_w;
        end else if (b_zero) begin
            spec_res   = inf_w;
            spec_flags = 4'b0100;
        end else if (a_zero || b_inf) begin
            spec_res = zero_w;
        end else begin
            spec_hit = 1'b0;
        end
    end

    // one restoring step: trial subtract, keep the difference when no borrow
    logic        borrow;
    logic [MW:0] diff;
    logic [MW:0] rem_nxt;

    assign {borrow, diff} = {1'b0, rem} - {2'b00, dvs};
    assign rem_nxt        = (borrow ? rem : diff) << 1;

    logic [MW-1:0]        mant;
    logic                 guard, sticky, rnd_up;
    logic [MW:0]          mant_r;
    logic signed [EW+1:0] exp_n, exp_r;
    logic [FW-1:0]        frac_r;
    logic [W-1:0]         norm_res;
    logic [3:0]           norm_flags;

    // normalize by at most one place, round to nearest even, then range check
    always_comb begin
        if (quo[QW-1]) begin
            mant   = quo[QW-1:2];
            guard  = quo[1];
            sticky = quo[0] | (|rem);
            exp_n  = exp_q;
        end else begin
            mant   = quo[QW-2:1];
            guard  = quo[0];
            sticky = |rem;
            exp_n  = exp_q - ONE_X;
        end
        rnd_up = guard & (sticky | mant[0]);
        mant_r = {1'b0, mant} + {{MW{1'b0}}, rnd_up};
        exp_r  = exp_n + $signed({{(EW + 1){1'b0}}, mant_r[MW]});
        frac_r = mant_r[MW] ? mant_r[FW:1] : mant_r[FW-1:0];
        norm_flags = 4'b0000;
        if (exp_r >= EMAX_X) begin
            norm_res   = inf_w;
            norm_flags = 4'b0010;
        end else if (exp_r <= ZERO_X) begin
            norm_res   = zero_w;
            norm_flags = 4'b0001;
        end else begin
            norm_res = {sq, exp_r[EW-1:0], frac_r};
        end
    end

    // sequencing FSM with registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            first     <= 1'b0;
            rem       <= '0;
            dvs       <= '0;
            quo       <= '0;
            exp_q     <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= a;
                        b_q      <= b;
                        flags    <= '0;
                        first    <= 1'b1;
                        in_ready <= 1'b0;
                        state    <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    if (first) begin
                        first <= 1'b0;
                        if (spec_hit) begin
                            result    <= spec_res;
                            flags     <= spec_flags;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            rem   <= {2'b01, fa};
                            dvs   <= {1'b1, fb};
                            quo   <= '0;
                            exp_q <= exp_init;
                            cnt   <= CW'(QW - 1);
                        end
                    end else begin
                        quo <= {quo[QW-2:0], ~borrow};
                        rem <= rem_nxt;
                        if (cnt == '0) begin
                            state <= NORM;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                end
                NORM: begin
                    result    <= norm_res;
                    flags     <= norm_flags;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_divide.sv
// tb_fpu_divide: scoreboard bench for fpu_divide, one single- and one double-precision instance.
module tb_fpu_divide;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]  iv, ir, ov, ordy;
    logic [31:0] a_sp, b_sp, res_sp;
    logic [63:0] a_dp, b_dp, res_dp;
    logic [3:0]  flg_sp, flg_dp;

    fpu_divide #(.double(0)) u_sp (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a_sp), .b(b_sp), .out_valid(ov[0]), .out_ready(ordy[0]),
        .result(res_sp), .flags(flg_sp)
    );

    fpu_divide #(.double(1)) u_dp (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a_dp), .b(b_dp), .out_valid(ov[1]), .out_ready(ordy[1]),
        .result(res_dp), .flags(flg_dp)
    );

    typedef struct {
        logic [63:0] res;
        logic [3:0]  flg;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   bp_mode = 2;     // 0 random out_ready, 1 held low, 2 held high
    logic [1:0] seen;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sb_size(input int k);
        return (k != 0) ? sb1.size() : sb0.size();
    endfunction

    function automatic exp_t sb_front(input int k);
        return (k != 0) ? sb1[0] : sb0[0];
    endfunction

    task automatic sb_pop(input int k);
        if (k != 0) void'(sb1.pop_front());
        else        void'(sb0.pop_front());
    endtask

    task automatic sb_push(input int k, input exp_t e);
        if (k != 0) sb1.push_back(e);
        else        sb0.push_back(e);
    endtask

    function automatic logic [63:0] res_of(input int k);
        return (k != 0) ? res_dp : {32'h0, res_sp};
    endfunction

    function automatic logic [3:0] flg_of(input int k);
        return (k != 0) ? flg_dp : flg_sp;
    endfunction

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    function automatic exp_t mk(input logic [63:0] r, input logic [3:0] f, input int l);
        exp_t e;
        e.res = r;
        e.flg = f;
        e.lat = l;
        e.acc = 0;
        return e;
    endfunction

    // reference: exact integer quotient with round-to-nearest-even, DAZ and FTZ
    function automatic exp_t ref_div(input int k, input logic [63:0] x, input logic [63:0] y);
        exp_t         r;
        int           ew, fw, bias, emax, e;
        logic [63:0]  fmask, ea, eb, fa, fb, inf_v, zero_v, qnan;
        logic         s, xn, yn, xi, yi, xz, yz;
        logic [127:0] ma, mb, num, q, rm;
        ew     = (k != 0) ? 11 : 8;
        fw     = (k != 0) ? 52 : 23;
        bias   = (1 << (ew - 1)) - 1;
        emax   = (1 << ew) - 1;
        fmask  = (64'd1 << fw) - 64'd1;
        ea     = (x >> fw) & 64'(emax);
        eb     = (y >> fw) & 64'(emax);
        fa     = x & fmask;
        fb     = y & fmask;
        s      = x[ew+fw] ^ y[ew+fw];
        zero_v = 64'(s) << (ew + fw);
        inf_v  = zero_v | (64'(emax) << fw);
        qnan   = (k != 0) ? 64'h7FF8_0000_0000_0000 : 64'h0000_0000_7FC0_0000;
        xn = (ea == 64'(emax)) && (fa != 0);
        yn = (eb == 64'(emax)) && (fb != 0);
        xi = (ea == 64'(emax)) && (fa == 0);
        yi = (eb == 64'(emax)) && (fb == 0);
        xz = (ea == 0);
        yz = (eb == 0);
        r.flg = 4'b0000;
        r.lat = 1;
        r.acc = 0;
        r.res = zero_v;
        if (xn || yn) begin
            r.res = qnan;
        end else if ((xz && yz) || (xi && yi)) begin
            r.res = qnan;
            r.flg = 4'b1000;
        end else if (xi) begin
            r.res = inf_v;
        end else if (yz) begin
            r.res = inf_v;
            r.flg = 4'b0100;
        end else if (xz || yi) begin
            r.res = zero_v;
        end else begin
            r.lat = fw + 5;
            ma = 128'(fa | (64'd1 << fw));
            mb = 128'(fb | (64'd1 << fw));
            e  = int'(ea) - int'(eb) + bias;
            if (ma >= mb) begin
                num = ma << fw;
            end else begin
                num = ma << (fw + 1);
                e   = e - 1;
            end
            q  = num / mb;
            rm = num % mb;
            if ((rm << 1) > mb || ((rm << 1) == mb && q[0])) q = q + 128'd1;
            if (q == (128'd1 << (fw + 1))) begin
                q = q >> 1;
                e = e + 1;
            end
            if (e >= emax) begin
                r.res = inf_v;
                r.flg = 4'b0010;
            end else if (e <= 0) begin
                r.res = zero_v;
                r.flg = 4'b0001;
            end else begin
                r.res = zero_v | (64'(e) << fw) | (q[63:0] & fmask);
            end
        end
        return r;
    endfunction

    function automatic logic [63:0] rnd_op(input int k);
        int          ew, fw, emax, bias;
        logic [63:0] e, f, s;
        ew   = (k != 0) ? 11 : 8;
        fw   = (k != 0) ? 52 : 23;
        emax = (1 << ew) - 1;
        bias = (1 << (ew - 1)) - 1;
        f    = {$urandom, $urandom} & ((64'd1 << fw) - 64'd1);
        s    = 64'($urandom_range(0, 1));
        case ($urandom_range(0, 15))
            0: begin
                e = 64'd0;
                if ($urandom_range(0, 1) == 0) f = 64'd0;
            end
            1: begin
                e = 64'(emax);
                if ($urandom_range(0, 1) == 0) f = 64'd0;
            end
            2: e = 64'($urandom_range(1, 6));
            3: e = 64'(emax - 1 - int'($urandom_range(0, 6)));
            4: begin
                e = 64'(bias - 3 + int'($urandom_range(0, 6)));
                f = 64'd0;
            end
            default: e = 64'(bias - 30 + int'($urandom_range(0, 60)));
        endcase
        return (s << (ew + fw)) | (e << fw) | f;
    endfunction

    task automatic issue(input int k, input logic [63:0] x, input logic [63:0] y, input exp_t e);
        int n;
        @(posedge clk);
        #1;
        if (k == 0) begin
            a_sp = x[31:0];
            b_sp = y[31:0];
        end else begin
            a_dp = x;
            b_dp = y;
        end
        iv[k] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!ir[k] && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!ir[k]) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout k%0d: in_ready stayed %b, required 1", k, ir[k]);
            iv[k] = 1'b0;
            return;
        end
        e.acc = cyc + 1;
        sb_push(k, e);
        @(posedge clk);
        #1;
        iv[k] = 1'b0;
    endtask

    task automatic drain(input int k);
        int n;
        n = 0;
        while (sb_size(k) != 0 && n < 20000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb_size(k) != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout k%0d: %0d results outstanding, required 0", k, sb_size(k));
            if (k != 0) sb1.delete();
            else        sb0.delete();
        end
        @(negedge clk);
        #1;
    endtask

    // monitor: latency on first out_valid, result/flags on the handshake
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            seen = 2'b00;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (ov[k]) begin
                    if (sb_size(k) == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_out k%0d: got %h with nothing outstanding", k, res_of(k));
                    end else begin
                        e = sb_front(k);
                        if (!seen[k]) begin
                            seen[k] = 1'b1;
                            check($sformatf("latency k%0d", k), 68'(cyc - e.acc), 68'(e.lat));
                        end
                        if (ordy[k]) begin
                            check($sformatf("result k%0d", k), {flg_of(k), res_of(k)}, {e.flg, e.res});
                            sb_pop(k);
                            seen[k] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // out_ready driver
    initial begin
        ordy = 2'b00;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                case (bp_mode)
                    0:       ordy[k] = ($urandom_range(0, 3) != 0);
                    1:       ordy[k] = 1'b0;
                    default: ordy[k] = 1'b1;
                endcase
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    logic [31:0] da [7] = '{32'h40C00000, 32'h3F800000, 32'h40400000, 32'h00000000,
                            32'hFF800000, 32'h7F000000, 32'h00800000};
    logic [31:0] db [7] = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h00000000,
                            32'h40000000, 32'h3E800000, 32'h40800000};
    logic [31:0] dr [7] = '{32'h40400000, 32'h3EAAAAAB, 32'h7F800000, 32'h7FC00000,
                            32'hFF800000, 32'h7F800000, 32'h00000000};
    logic [3:0]  df [7] = '{4'h0, 4'h0, 4'h4, 4'h8, 4'h0, 4'h2, 4'h1};
    int          dl [7] = '{28, 28, 1, 1, 1, 28, 28};

    initial begin
        int n;
        rst_n = 1'b0;
        iv    = 2'b00;
        a_sp  = '0;
        b_sp  = '0;
        a_dp  = '0;
        b_dp  = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++)
            check($sformatf("reset_state k%0d", k), {ir[k], ov[k], flg_of(k), res_of(k)},
                  {1'b1, 1'b0, 4'h0, 64'h0});
        rst_n = 1'b1;

        // directed single precision
        bp_mode = 2;
        for (int i = 0; i < 7; i++) begin
            issue(0, {32'h0, da[i]}, {32'h0, db[i]}, mk({32'h0, dr[i]}, df[i], dl[i]));
            drain(0);
        end

        // backpressure: hold out_ready low for 10 cycles after out_valid
        bp_mode = 1;
        issue(0, 64'h40C00000, 64'h40000000, mk(64'h40400000, 4'h0, 28));
        n = 0;
        @(negedge clk);
        while (!ov[0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (10) begin
            @(negedge clk);
            check("bp_hold", {ir[0], ov[0], flg_sp, res_sp}, {1'b0, 1'b1, 4'h0, 32'h40400000});
        end
        bp_mode = 2;
        drain(0);
        check("in_ready_after_handshake", {ir[0], ov[0]}, 2'b10);
        issue(0, 64'h3F800000, 64'h40400000, mk(64'h3EAAAAAB, 4'h0, 28));
        drain(0);

        // reset in the middle of DIVIDE
        issue(0, 64'h40C00000, 64'h40000000, mk(64'h40400000, 4'h0, 28));
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_abort", {ir[0], ov[0], flg_sp, res_sp}, {1'b1, 1'b0, 4'h0, 32'h0});
        sb0.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(0, 64'h40C00000, 64'h40000000, mk(64'h40400000, 4'h0, 28));
        drain(0);

        // directed double precision
        issue(1, 64'h4018000000000000, 64'h4000000000000000, mk(64'h4008000000000000, 4'h0, 57));
        drain(1);
        issue(1, 64'h3FF0000000000000, 64'h4008000000000000, mk(64'h3FD5555555555555, 4'h0, 57));
        drain(1);

        // randomized against the reference model, random out_ready
        bp_mode = 0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    logic [63:0] x, y;
                    x = rnd_op(0);
                    y = rnd_op(0);
                    issue(0, x, y, ref_div(0, x, y));
                end
            end
            begin
                for (int j = 0; j < 60; j++) begin
                    logic [63:0] x, y;
                    x = rnd_op(1);
                    y = rnd_op(1);
                    issue(1, x, y, ref_div(1, x, y));
                end
            end
        join
        drain(0);
        drain(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
